// File: rtl/bcd_display_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Seven-segment patterns and BCD nibble decoder shared by the scanner.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

    localparam int DIGIT_W = 4;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Non-decimal codes show a dash so a corrupt upstream value is visible
    function automatic logic [6:0] bcd_to_seg(input logic [DIGIT_W-1:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner_if
// Purpose  : Value capture inputs and multiplexed display outputs of the scanner.
// Revision : 1.0
// ============================================================================
interface bcd_display_scanner_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in;
    logic                          bcd_valid;
    logic [NUM_DIGITS-1:0]         dp_in;
    logic [6:0]                    seg;
    logic                          dp;
    logic [NUM_DIGITS-1:0]         an;
    logic                          frame_start;
    logic                          pending;

    modport master (
        output bcd_in, bcd_valid, dp_in,
        input  seg, dp, an, frame_start, pending
    );

    modport slave (
        input  bcd_in, bcd_valid, dp_in,
        output seg, dp, an, frame_start, pending
    );
endinterface
`default_nettype wire

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Purpose  : Combinational BCD nibble to active-high seven-segment decoder.
// Revision : 1.0
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  wire logic [DIGIT_W-1:0] i_bcd,
    output      logic [6:0]         o_seg
);
    assign o_seg = bcd_to_seg(i_bcd);
endmodule
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner
// Purpose  : Double-buffered, time-multiplexed 7-segment scanner with blanking.
// Revision : 1.0
// ============================================================================
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DWELL_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit BLANK_LEADING  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
)(
    input wire logic             clk,
    input wire logic             rst,
    bcd_display_scanner_if.slave bus
);
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BUS_W = DIGIT_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      c_cnt_max   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      c_blank_cnt = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      c_idx_max   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_seg_inv   = {7{SEG_ACTIVE_LOW}};
    localparam logic                  c_dp_inv    = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] c_an_inv    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    generate
        if (DWELL_CYCLES < BLANK_CYCLES + 1) begin : g_bad_timing
            $error("DWELL_CYCLES must be at least BLANK_CYCLES+1");
        end
    endgenerate

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [BUS_W-1:0]      r_stage;
    logic [NUM_DIGITS-1:0] r_stage_dp;
    logic [BUS_W-1:0]      r_disp;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic                  r_pending;
    logic                  r_frame_start;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_tick;
    logic                  w_wrap;
    logic [DIGIT_W-1:0]    w_digit;
    logic                  w_dp_sel;
    logic                  w_blank;
    logic                  w_zero_above;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_an_hot;
    logic [6:0]            w_seg_raw;

    assign w_tick = (r_cnt == c_cnt_max);
    assign w_wrap = w_tick && (r_idx == c_idx_max);

    // Walk from the most significant digit so w_zero_above covers digit i and everything above it
    always_comb begin
        w_digit      = '0;
        w_dp_sel     = 1'b0;
        w_blank      = 1'b0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_disp[i*DIGIT_W +: DIGIT_W] == '0);
            if (r_idx == IDX_W'(i)) begin
                w_digit  = r_disp[i*DIGIT_W +: DIGIT_W];
                w_dp_sel = r_disp_dp[i];
                w_blank  = BLANK_LEADING && (i != 0) && w_zero_above;
            end
        end
    end

    always_comb begin
        w_lit    = (r_cnt >= c_blank_cnt) && !w_blank;
        w_an_hot = '0;
        if (w_lit) begin
            w_an_hot[r_idx] = 1'b1;
        end
    end

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stage       <= '0;
            r_stage_dp    <= '0;
            r_disp        <= '0;
            r_disp_dp     <= '0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_an          <= c_an_inv;
            r_seg         <= c_seg_inv;
            r_dp          <= c_dp_inv;
        end else begin
            r_frame_start <= w_wrap;
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (bus.bcd_valid) begin
                r_stage    <= bus.bcd_in;
                r_stage_dp <= bus.dp_in;
                r_pending  <= 1'b1;
            end

            // A valid coinciding with the wrap bypasses staging so it is not lost for a frame
            if (w_wrap) begin
                if (bus.bcd_valid) begin
                    r_disp    <= bus.bcd_in;
                    r_disp_dp <= bus.dp_in;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_disp    <= r_stage;
                    r_disp_dp <= r_stage_dp;
                    r_pending <= 1'b0;
                end
            end

            r_an  <= w_an_hot ^ c_an_inv;
            r_seg <= (w_lit ? w_seg_raw : SEG_OFF) ^ c_seg_inv;
            r_dp  <= (w_lit && w_dp_sel) ^ c_dp_inv;
        end
    end

    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;
    assign bus.an          = r_an;
    assign bus.frame_start = r_frame_start;
    assign bus.pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_scanner
// Purpose  : Scoreboard bench for the scanner, with and without leading-zero blanking.
// Revision : 1.0
// ============================================================================
module tb_bcd_display_scanner;
    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int BK    = 1;
    localparam int FRAME = N * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_display_scanner_if #(.NUM_DIGITS(N)) bus0 ();
    bcd_display_scanner_if #(.NUM_DIGITS(N)) bus1 ();

    assign bus1.bcd_in    = bus0.bcd_in;
    assign bus1.bcd_valid = bus0.bcd_valid;
    assign bus1.dp_in     = bus0.dp_in;

    bcd_display_scanner #(
        .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BK),
        .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    bcd_display_scanner #(
        .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BK),
        .BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Active-high reference patterns {g,f,e,d,c,b,a}; codes A-F are a dash
    logic [6:0] seg_tab [16];
    initial seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Entries are {an, seg, dp} as seen on the active-low pins
    logic [11:0] q0 [$];
    logic [11:0] q1 [$];
    localparam logic [11:0] OFF = 12'hFFF;

    logic [15:0] m_disp, m_stage;
    logic [3:0]  m_dp, m_stage_dp;
    bit          m_pending;

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
        bit       nz;
        bit [3:0] lit0;
        nz = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            nz      = nz || (v[i*4 +: 4] != 4'h0);
            lit0[i] = nz || (i == 0);
        end
        for (int i = 0; i < N; i++) begin
            logic [11:0] e;
            logic [3:0]  one_hot;
            one_hot = 4'b0001 << i;
            e = {~one_hot, ~seg_tab[v[i*4 +: 4]], ~d[i]};
            if (lit0[i]) q0.push_back(e);
            q1.push_back(e);
        end
    endtask

    logic [11:0] obs0, obs1, cur0, cur1;
    int          run0 = 0;
    int          run1 = 0;

    always @(negedge clk) begin
        obs0 = {bus0.an, bus0.seg, bus0.dp};
        if (bus0.an != 4'hF) begin
            if (run0 == 0) begin
                if (q0.size() == 0) begin
                    check("sb0_unexpected_lit", obs0, OFF);
                    cur0 = OFF;
                end else begin
                    cur0 = q0.pop_front();
                end
            end
            check("sb0_lit", obs0, cur0);
            run0++;
        end else begin
            if (run0 != 0 && !rst) check("sb0_dwell", run0, DW - BK);
            check("sb0_off", obs0, OFF);
            run0 = 0;
        end
    end

    always @(negedge clk) begin
        obs1 = {bus1.an, bus1.seg, bus1.dp};
        if (bus1.an != 4'hF) begin
            if (run1 == 0) begin
                if (q1.size() == 0) begin
                    check("sb1_unexpected_lit", obs1, OFF);
                    cur1 = OFF;
                end else begin
                    cur1 = q1.pop_front();
                end
            end
            check("sb1_lit", obs1, cur1);
            run1++;
        end else begin
            if (run1 != 0 && !rst) check("sb1_dwell", run1, DW - BK);
            check("sb1_off", obs1, OFF);
            run1 = 0;
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus0.bcd_valid = 1'b0;
        q0.delete();
        q1.delete();
        m_disp = '0; m_dp = '0; m_pending = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("rst_an", bus0.an, 4'hF);
            check("rst_seg", bus0.seg, 7'h7F);
            check("rst_dp", bus0.dp, 1'b1);
            check("rst_pending", bus0.pending, 1'b0);
            check("rst_frame_start", bus0.frame_start, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_an", bus0.an, 4'hF);
        check("post_rst_pending", bus0.pending, 1'b0);
        push_frame(m_disp, m_dp);
    endtask

    task automatic pulse(input logic [15:0] v, input logic [3:0] d);
        bus0.bcd_in = v; bus0.dp_in = d; bus0.bcd_valid = 1'b1;
        m_stage = v; m_stage_dp = d; m_pending = 1'b1;
        @(negedge clk);
        bus0.bcd_valid = 1'b0;
        check("pending_set", bus0.pending, 1'b1);
    endtask

    // Returns one cycle after the frame_start cycle
    task automatic wait_frame();
        int k;
        k = 0;
        @(negedge clk);
        bus0.bcd_valid = 1'b0;
        while (!bus0.frame_start && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check("frame_start_seen", bus0.frame_start, 1'b1);
        if (bus0.frame_start) begin
            check("sb0_drained", q0.size(), 0);
            check("sb1_drained", q1.size(), 0);
            check("pending_at_wrap", bus0.pending, 1'b0);
            if (m_pending) begin
                m_disp = m_stage; m_dp = m_stage_dp; m_pending = 1'b0;
            end
            push_frame(m_disp, m_dp);
            @(negedge clk);
            check("frame_start_pulse", bus0.frame_start, 1'b0);
        end
    endtask

    initial begin
        bus0.bcd_in = '0; bus0.dp_in = '0; bus0.bcd_valid = 1'b0;
        m_stage = '0; m_stage_dp = '0;
        do_reset(3);
        wait_frame();
        wait_frame();
        check("pending_idle", bus0.pending, 1'b0);

        pulse(16'h1234, 4'b0000);
        wait_frame();
        wait_frame();

        pulse(16'h0007, 4'b0001);
        wait_frame();
        wait_frame();
        pulse(16'h0000, 4'b0000);
        wait_frame();
        wait_frame();
        pulse(16'h00A5, 4'b0100);
        wait_frame();
        wait_frame();

        // Valid lands exactly on the wrap tick
        repeat (14) @(negedge clk);
        bus0.bcd_in = 16'h5678; bus0.dp_in = 4'b1000; bus0.bcd_valid = 1'b1;
        m_stage = 16'h5678; m_stage_dp = 4'b1000; m_pending = 1'b1;
        wait_frame();
        wait_frame();

        pulse(16'h1111, 4'b1111);
        repeat (3) @(negedge clk);
        pulse(16'h2222, 4'b0010);
        wait_frame();
        wait_frame();

        // Reset while digit 2 is lit, with a staged value still pending
        pulse(16'h9999, 4'b0000);
        repeat (9) @(negedge clk);
        do_reset(2);
        wait_frame();
        wait_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the binary-to-BCD converter's digit outputs.
- Captures a packed BCD value with a valid strobe and double-buffers it, so the displayed value changes only at frame boundaries (no tearing).
- Time-multiplexes the digits onto a shared 7-segment bus with per-digit dwell, an anti-ghosting blank interval, and optional leading-zero blanking.

Parameters:
NUM_DIGITS, 4, number of BCD digits and anodes; digit 0 = units.
DWELL_CYCLES, 50000, clk cycles each digit slot lasts; must be >= BLANK_CYCLES+1 (elaboration error otherwise).
BLANK_CYCLES, 2, cycles at start of each slot with all anodes off.
BLANK_LEADING, 1, 1 = suppress leading zeros.
SEG_ACTIVE_LOW, 1, invert seg and dp outputs.
AN_ACTIVE_LOW, 1, invert an outputs.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
bcd_in  in  4*NUM_DIGITS  packed BCD, digit i at [4i+3:4i]
bcd_valid  in  1  capture strobe for bcd_in
dp_in  in  NUM_DIGITS  decimal point per digit, sampled with bcd_in
seg  out  7  {g,f,e,d,c,b,a}
dp  out  1  decimal point of active digit
an  out  NUM_DIGITS  digit enables
frame_start  out  1  1-cycle pulse at each frame wrap
pending  out  1  staged value not yet displayed

Behaviour:
- Reset (synchronous, overrides every input including bcd_valid): cnt=0, idx=0, staging=0, display=0, dp regs=0, pending=0, frame_start=0. an, seg and dp go to their inactive levels (all 1 when active-low) on the first edge with rst=1.
- Slot counter: cnt counts 0..DWELL_CYCLES-1. tick = (cnt==DWELL_CYCLES-1). On tick: cnt<=0 and idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
- Capture: bcd_valid=1 loads bcd_in and dp_in into staging and sets pending=1. Multiple valids within one frame: last one wins.
- Frame transfer happens on a tick with idx==NUM_DIGITS-1:
  - frame_start=1 for that one cycle.
  - If bcd_valid is also 1 that cycle: bcd_in/dp_in bypass straight into display, staging is also updated, pending=0.
  - Else if pending=1: staging -> display, pending=0.
  - Else: display holds.
- Outputs are registered from current (idx, cnt, display), so they lag the index by 1 cycle. Digit idx is lit iff cnt>=BLANK_CYCLES and the digit is not blanked. A non-lit slot drives all anodes and seg/dp inactive.
- Leading-zero blanking (BLANK_LEADING=1): digit i>0 is blanked iff it and every more-significant digit equal 0. Digit 0 is never blanked. With BLANK_LEADING=0, nothing is blanked.
- Decode (active-high, before polarity inversion): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Any code A-F decodes to dash 40 (segment g only). Invalid codes count as nonzero for blanking purposes.
- Polarity: SEG_ACTIVE_LOW inverts seg and dp. AN_ACTIVE_LOW inverts an. At most one anode is active in any cycle.
- After reset, display=0, so the first frame shows a single "0" on digit 0 (others blanked when BLANK_LEADING=1).

Decomposition:
- Package seg7_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_DASH, SEG_OFF;
  - the digit-width localparam (4);
  - a pure function that decodes one BCD nibble to 7 segments.
- One combinational sub-module, bcd_to_seg7 (nibble in, active-high segments out), instantiated once on the muxed digit.
- Counters, buffers and the blanking logic stay in the top-level module.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=1, both polarities active-low):
1. rst held 3 cycles, then released -> an=1111, seg=7F, dp=1 during reset and on the first cycle after release. From cycle 2: an=1110, seg=40 ("0"), lasting 3 cycles per frame. Digits 1-3 never lit. pending=0.
2. bcd_valid pulse with bcd_in=1234 -> pending=1 until the wrap tick (frame_start=1, pending=0 on that edge). Next frame: an 1110/1101/1011/0111 with seg 19/30/24/79 (4,3,2,1). Each preceded by 1 all-off cycle.
3. bcd_in=0007 -> only an=1110 lit, seg=78. bcd_in=0000 -> digit 0 shows 40. With BLANK_LEADING=0, bcd_in=0007 -> digits 1-3 show 40.
4. bcd_in=00A5 -> digit 0 seg=12 (5), digit 1 seg=3F (dash), digits 2-3 blanked.
5. bcd_valid=1 with bcd_in=5678 exactly on the wrap tick -> the following frame shows 5678 and pending=0. Two valids (1111 then 2222) within one frame -> only 2222 is ever displayed.
6. rst asserted mid-slot at idx=2 -> outputs inactive on the next edge. After release, scanning restarts at digit 0 and display=0, so only "0" is shown.
